// File: rtl/spi_master_cfg.sv
// spi_master_cfg: parametrised SPI master supporting all four SPI modes, per-frame CPOL/CPHA,
// configurable frame width, SCLK divider and several chip selects.
//
// Parameters
//   DATA_W   frame width in bits (>= 2)
//   CLK_DIV  clk cycles per SCLK half-period (>= 1)
//   NUM_CS   number of chip-select lines (>= 1)
//
// Ports
//   clk, rst_n         system clock, asynchronous active-low reset
//   start              frame request, only looked at while idle
//   cpol, cpha         SPI mode, latched when a frame is accepted
//   cs_sel             target slave index, latched when a frame is accepted
//   data_in            transmit word, latched when a frame is accepted
//   lsb_first          (SPI_LSB_FIRST_EN builds only) shift LSB first, latched at start
//   data_out           received word, updated when a frame finishes
//   busy, done         frame in progress / one-cycle end-of-frame pulse
//   sclk, mosi, miso   SPI bus
//   cs_n               active-low chip selects
//
// Build option: define SPI_LSB_FIRST_EN to add the lsb_first input. Without it frames are
// always MSB first. Timing is identical in both builds.

module spi_master_cfg #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned NUM_CS  = 1,
  localparam int unsigned CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              cpol,
  input  logic              cpha,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic [DATA_W-1:0] data_in,
`ifdef SPI_LSB_FIRST_EN
  input  logic              lsb_first,
`endif
  output logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              done,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_CS-1:0] cs_n
);

  localparam int unsigned DivW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned HalfW = $clog2(2 * DATA_W);

  localparam logic [DivW-1:0]  DivLast  = DivW'(CLK_DIV - 1);
  localparam logic [HalfW-1:0] HalfLast = HalfW'(2 * DATA_W - 1);
  // One extra bit so NUM_CS == 2**CS_W is representable.
  localparam logic [CS_W:0]    NumCsL   = (CS_W + 1)'(NUM_CS);

  typedef enum logic [2:0] {StIdle, StSetup, StXfer, StHold, StFinish} state_e;

  state_e              state_q, state_d;
  logic [DivW-1:0]     div_q, div_d;
  logic [HalfW-1:0]    half_q, half_d;
  logic                cpol_q, cpol_d;
  logic                cpha_q, cpha_d;
  logic [DATA_W-1:0]   tx_q, tx_d;
  logic [DATA_W-1:0]   rx_q, rx_d;
  logic [DATA_W-1:0]   data_out_q, data_out_d;
  logic                sclk_q, sclk_d;
  logic                mosi_q, mosi_d;
  logic [NUM_CS-1:0]   cs_n_q, cs_n_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                lsb_in;   // bit order requested for the frame being accepted
  logic                lsb_cur;  // bit order of the frame in flight
  logic                cs_ok;
  logic                div_end;
  logic                lead;
  logic [NUM_CS-1:0]   cs_dec;

`ifdef SPI_LSB_FIRST_EN
  logic lsb_q, lsb_d;
  assign lsb_in  = lsb_first;
  assign lsb_cur = lsb_q;
`else
  assign lsb_in  = 1'b0;
  assign lsb_cur = 1'b0;
`endif

  assign cs_ok   = ({1'b0, cs_sel} < NumCsL);
  assign div_end = (div_q == DivLast);
  // Toggle number half_q+1 is odd (leading edge) when half_q is even.
  assign lead    = ~half_q[0];

  always_comb begin
    cs_dec = '1;
    for (int i = 0; i < int'(NUM_CS); i++) begin
      cs_dec[i] = (cs_sel != CS_W'(i));
    end
  end

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    half_d     = half_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    data_out_d = data_out_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    cs_n_d     = cs_n_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
`ifdef SPI_LSB_FIRST_EN
    lsb_d      = lsb_q;
`endif

    unique case (state_q)
      StIdle: begin
        sclk_d = cpol;
        if (start && cs_ok) begin
          state_d = StSetup;
          div_d   = '0;
          half_d  = '0;
          cpol_d  = cpol;
          cpha_d  = cpha;
          rx_d    = '0;
          busy_d  = 1'b1;
          cs_n_d  = cs_dec;
`ifdef SPI_LSB_FIRST_EN
          lsb_d   = lsb_first;
`endif
          if (!cpha) begin
            // Mode with sampling on the leading edge: first bit must be on the wire now.
            mosi_d = lsb_in ? data_in[0] : data_in[DATA_W-1];
            tx_d   = lsb_in ? (data_in >> 1) : (data_in << 1);
          end else begin
            tx_d   = data_in;
          end
        end
      end

      StSetup: begin
        sclk_d = cpol_q;
        div_d  = div_end ? '0 : div_q + 1'b1;
        if (div_end) begin
          state_d = StXfer;
        end
      end

      StXfer: begin
        div_d = div_end ? '0 : div_q + 1'b1;
        if (div_end) begin
          sclk_d = ~sclk_q;
          half_d = half_q + 1'b1;
          if (lead ^ cpha_q) begin
            // Sampling edge: miso captured together with the sclk transition.
            rx_d = lsb_cur ? {miso, rx_q[DATA_W-1:1]} : {rx_q[DATA_W-2:0], miso};
          end else if (cpha_q || (half_q != HalfLast)) begin
            mosi_d = lsb_cur ? tx_q[0] : tx_q[DATA_W-1];
            tx_d   = lsb_cur ? (tx_q >> 1) : (tx_q << 1);
          end
          if (half_q == HalfLast) begin
            state_d = StHold;
            half_d  = '0;
          end
        end
      end

      StHold: begin
        sclk_d = cpol_q;
        div_d  = div_end ? '0 : div_q + 1'b1;
        if (div_end) begin
          state_d = StFinish;
        end
      end

      StFinish: begin
        state_d    = StIdle;
        cs_n_d     = '1;
        data_out_d = rx_q;
        done_d     = 1'b1;
        busy_d     = 1'b0;
      end

      default: begin
        state_d = StIdle;
        cs_n_d  = '1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      div_q      <= '0;
      half_q     <= '0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      tx_q       <= '0;
      rx_q       <= '0;
      data_out_q <= '0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= '1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef SPI_LSB_FIRST_EN
      lsb_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      half_q     <= half_d;
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      data_out_q <= data_out_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      cs_n_q     <= cs_n_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef SPI_LSB_FIRST_EN
      lsb_q      <= lsb_d;
`endif
    end
  end

  assign data_out = data_out_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign sclk     = sclk_q;
  assign mosi     = mosi_q;
  assign cs_n     = cs_n_q;

endmodule

// File: doc/spi_master_cfg.md
Name: spi_master_cfg

Overview:
Parametrised SPI master, the successor to the team's fixed 8-bit mode-0 SPI master FSM. Adds configurable frame width and SCLK divider, all four SPI modes (per-frame CPOL/CPHA), and multiple chip selects. Entirely synchronous to clk, with no delay constructs, so it is synthesisable. Sits between a host-side register/command interface and off-chip SPI slaves.

Parameters:
DATA_W, 8, frame width in bits; legal range >= 2.
CLK_DIV, 2, clk cycles per SCLK half-period; legal range >= 1.
NUM_CS, 1, number of chip-select lines; legal range >= 1.
CS_W (localparam), max(1, clog2(NUM_CS)), width of cs_sel.

Ports:
clk  in  1  system clock; all logic on posedge.
rst_n  in  1  asynchronous, active-low reset.
start  in  1  frame request; sampled only in IDLE.
cpol  in  1  SCLK idle level; latched at start.
cpha  in  1  0 = sample on leading edge, 1 = sample on trailing edge; latched at start.
cs_sel  in  CS_W  target slave index; latched at start.
data_in  in  DATA_W  transmit word; latched at start.
data_out  out  DATA_W  received word; updated only at frame end.
busy  out  1  high from start acceptance until done.
done  out  1  one-cycle pulse at frame end.
sclk  out  1  SPI clock.
mosi  out  1  master data out.
miso  in  1  slave data in.
cs_n  out  NUM_CS  active-low chip selects.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state = IDLE; sclk=0, mosi=0, cs_n = all 1s, busy=0, done=0, data_out=0.
  - Shift registers, bit counter and divider counter all cleared.
  - Reset mid-frame aborts the frame immediately: no done pulse, data_out stays 0.
- States:
  - IDLE -> SETUP -> XFER -> HOLD -> FINISH -> IDLE.
- IDLE:
  - sclk follows the registered cpol input.
  - start=1 with cs_sel < NUM_CS is accepted at clock edge E0: latch the inputs, busy=1, cs_n[cs_sel]=0, enter SETUP.
  - start with cs_sel >= NUM_CS is ignored: busy, cs_n and done stay at idle values.
- Bit order:
  - MSB first (see optional feature).
  - For cpha=0, mosi is driven with bit DATA_W-1 at E0.
- SETUP:
  - Lasts CLK_DIV cycles; sclk = latched cpol.
- XFER:
  - 2*DATA_W half-periods of CLK_DIV cycles each; sclk toggles at the end of each half-period.
  - Odd toggles (1, 3, ...) are leading edges; even toggles are trailing edges.
  - cpha=0: sample miso on leading edges; drive the next mosi bit on trailing edges (no drive after the last trailing edge).
  - cpha=1: drive mosi on leading edges; sample miso on trailing edges.
  - miso is captured on the same clk edge that registers the sampling sclk transition.
  - Exactly DATA_W sampling edges per frame.
- HOLD:
  - CLK_DIV cycles, sclk = cpol, cs_n still asserted.
- FINISH (one cycle):
  - cs_n = all 1s, data_out = received word, done=1, busy=0.
  - Next state is IDLE.
- Latency:
  - done is high in the cycle beginning at edge E0 + (2*DATA_W+2)*CLK_DIV + 1.
- Boundary conditions:
  - start while busy: ignored; no queuing.
  - start asserted in the cycle after done: accepted (back-to-back frames allowed).
  - Changes to cpol/cpha/cs_sel/data_in mid-frame have no effect.
  - mosi holds its last value after the frame.
  - CLK_DIV=1 gives sclk = clk/2.

Optional Feature:
SPI_LSB_FIRST_EN:
- Defined: adds input port lsb_first (1 bit), latched at start. When 1, bit 0 is shifted first on mosi, and the first received bit lands in data_out[0].
- Undefined: the port is absent and frames are always MSB first.
- Timing and latency are identical in both builds.

Test Plan:
1. Mode 0, DATA_W=8, CLK_DIV=2, data_in=0xA5, miso looped to mosi -> 8 sclk rising edges, data_out=0xA5, done at E0+37, cs_n[0] low throughout.
2. Mode 3, slave model returns 0x3C, data_in=0xF0 -> sclk idles at 1, mosi bits 1,1,1,1,0,0,0,0 valid at rising edges, data_out=0x3C.
3. Modes 1 and 2, slave returns 0x81 -> data_out=0x81 in each mode; exactly 16 sclk toggles per frame.
4. NUM_CS=4, cs_sel=2 -> only cs_n[2] low; cs_sel=5 on an 8-slave-width index build -> start ignored, busy stays 0.
5. start pulsed mid-frame -> ignored. start in the cycle after done -> second frame begins; both frames return correct data.
6. rst_n low at half-period 7 -> cs_n=all 1s, sclk=0, busy=0, no done pulse; the next frame completes normally. With SPI_LSB_FIRST_EN and lsb_first=1, data_in=0x01 -> first mosi bit is 1.
